// File: rtl/mux4_scan_sequencer.sv
// Word-to-serial scanner for a 4:1 mux: latches an accepted word on mux_in, steps mux_sel
// through all four positions, and emits each sampled bit plus the reassembled word.
module mux4_scan_sequencer #(
   parameter int DWELL     = 1,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   output logic [3:0] mux_in,
   output logic [1:0] mux_sel,
   input  logic       mux_result,
   output logic       bit_valid,
   output logic       bit_out,
   output logic [1:0] bit_idx,
   output logic       word_valid,
   output logic [3:0] word_out,
   output logic       busy
);

   localparam int            CW        = $clog2(DWELL) + 1;
   localparam logic [CW-1:0] CNT_INIT  = CW'(DWELL - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [1:0]    SEL_START = MSB_FIRST ? 2'd3 : 2'd0;
   localparam logic [1:0]    SEL_LAST  = MSB_FIRST ? 2'd0 : 2'd3;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state_q, state_d;
   logic [3:0]    mux_in_q, mux_in_d;
   logic [1:0]    mux_sel_q, mux_sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    shadow_q, shadow_d;
   logic          bit_valid_q, bit_valid_d;
   logic          bit_out_q, bit_out_d;
   logic [1:0]    bit_idx_q, bit_idx_d;
   logic          word_valid_q, word_valid_d;
   logic [3:0]    word_out_q, word_out_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mux_in_q     <= 4'd0;
         mux_sel_q    <= SEL_START;
         cnt_q        <= CNT_INIT;
         shadow_q     <= 4'd0;
         bit_valid_q  <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_idx_q    <= 2'd0;
         word_valid_q <= 1'b0;
         word_out_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         mux_in_q     <= mux_in_d;
         mux_sel_q    <= mux_sel_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         bit_valid_q  <= bit_valid_d;
         bit_out_q    <= bit_out_d;
         bit_idx_q    <= bit_idx_d;
         word_valid_q <= word_valid_d;
         word_out_q   <= word_out_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mux_in_d     = mux_in_q;
      mux_sel_d    = mux_sel_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      bit_valid_d  = 1'b0;
      bit_out_d    = bit_out_q;
      bit_idx_d    = bit_idx_q;
      word_valid_d = 1'b0;
      word_out_d   = word_out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mux_in_d  = in_data;
               mux_sel_d = SEL_START;
               cnt_d     = CNT_INIT;
               shadow_d  = 4'd0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               bit_out_d           = mux_result;
               bit_idx_d           = mux_sel_q;
               bit_valid_d         = 1'b1;
               shadow_d[mux_sel_q] = mux_result;
               if (mux_sel_q == SEL_LAST) begin
                  // Merged shadow includes the bit sampled on this same edge.
                  word_out_d   = shadow_d;
                  word_valid_d = 1'b1;
                  mux_sel_d    = SEL_START;
                  state_d      = IDLE;
               end else begin
                  mux_sel_d = MSB_FIRST ? (mux_sel_q - 2'd1) : (mux_sel_q + 2'd1);
                  cnt_d     = CNT_INIT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = (state_q == IDLE) && !reset;
   assign mux_in     = mux_in_q;
   assign mux_sel    = mux_sel_q;
   assign bit_valid  = bit_valid_q;
   assign bit_out    = bit_out_q;
   assign bit_idx    = bit_idx_q;
   assign word_valid = word_valid_q;
   assign word_out   = word_out_q;
   assign busy       = (state_q == SCAN);

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Directed bench for mux4_scan_sequencer: three configurations, each closed through a 4:1 mux model.
module tb_mux4_scan_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // u0: DWELL=1 LSB-first, u1: DWELL=3 LSB-first, u2: DWELL=1 MSB-first
   logic       iv0, rdy0, mr0, bv0, bo0, wv0, bz0;
   logic [3:0] id0, mi0, wo0;
   logic [1:0] ms0, bx0;
   logic       iv1, rdy1, mr1, bv1, bo1, wv1, bz1;
   logic [3:0] id1, mi1, wo1;
   logic [1:0] ms1, bx1;
   logic       iv2, rdy2, mr2, bv2, bo2, wv2, bz2;
   logic [3:0] id2, mi2, wo2;
   logic [1:0] ms2, bx2;

   assign mr0 = mi0[ms0];
   assign mr1 = mi1[ms1];
   assign mr2 = mi2[ms2];

   mux4_scan_sequencer #(.DWELL(1), .MSB_FIRST(1'b0)) u0 (
      .clk(clk), .reset(reset), .in_valid(iv0), .in_data(id0), .in_ready(rdy0),
      .mux_in(mi0), .mux_sel(ms0), .mux_result(mr0), .bit_valid(bv0), .bit_out(bo0),
      .bit_idx(bx0), .word_valid(wv0), .word_out(wo0), .busy(bz0));
   mux4_scan_sequencer #(.DWELL(3), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .reset(reset), .in_valid(iv1), .in_data(id1), .in_ready(rdy1),
      .mux_in(mi1), .mux_sel(ms1), .mux_result(mr1), .bit_valid(bv1), .bit_out(bo1),
      .bit_idx(bx1), .word_valid(wv1), .word_out(wo1), .busy(bz1));
   mux4_scan_sequencer #(.DWELL(1), .MSB_FIRST(1'b1)) u2 (
      .clk(clk), .reset(reset), .in_valid(iv2), .in_data(id2), .in_ready(rdy2),
      .mux_in(mi2), .mux_sel(ms2), .mux_result(mr2), .bit_valid(bv2), .bit_out(bo2),
      .bit_idx(bx2), .word_valid(wv2), .word_out(wo2), .busy(bz2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] w;

   initial begin
      reset = 1'b1;
      iv0 = 1'b0; id0 = 4'd0;
      iv1 = 1'b0; id1 = 4'd0;
      iv2 = 1'b0; id2 = 4'd0;
      tick();
      tick();
      check("rst_ready", {31'd0, rdy0}, 32'd0);
      check("rst_busy", {31'd0, bz0}, 32'd0);
      check("rst_sel0", {30'd0, ms0}, 32'd0);
      check("rst_sel2", {30'd0, ms2}, 32'd3);
      check("rst_bv", {31'd0, bv0}, 32'd0);
      check("rst_wv", {31'd0, wv0}, 32'd0);
      check("rst_wo", {28'd0, wo0}, 32'd0);
      check("rst_mi", {28'd0, mi0}, 32'd0);
      reset = 1'b0;
      #1;
      check("idle_ready", {31'd0, rdy0}, 32'd1);

      // Test 1: DWELL=1 LSB-first, 1010 -> bits 0,1,0,1
      w = 4'b1010;
      iv0 = 1'b1; id0 = w;
      tick();
      iv0 = 1'b0;
      check("t1_busy", {31'd0, bz0}, 32'd1);
      check("t1_ready", {31'd0, rdy0}, 32'd0);
      check("t1_mi", {28'd0, mi0}, {28'd0, w});
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t1_bv", {31'd0, bv0}, 32'd1);
         check("t1_idx", {30'd0, bx0}, k);
         check("t1_bit", {31'd0, bo0}, {31'd0, w[k]});
         check("t1_wv", {31'd0, wv0}, (k == 3) ? 32'd1 : 32'd0);
      end
      check("t1_wo", {28'd0, wo0}, 32'hA);
      check("t1_ready_back", {31'd0, rdy0}, 32'd1);
      tick();
      check("t1_bv_low", {31'd0, bv0}, 32'd0);
      check("t1_wv_low", {31'd0, wv0}, 32'd0);
      check("t1_wo_hold", {28'd0, wo0}, 32'hA);

      // Test 2: DWELL=3, 0110
      w = 4'b0110;
      iv1 = 1'b1; id1 = w;
      tick();
      iv1 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check("t2_bv", {31'd0, bv1}, (k % 3 == 0) ? 32'd1 : 32'd0);
         check("t2_sel", {30'd0, ms1}, (k == 12) ? 32'd0 : k / 3);
         check("t2_wv", {31'd0, wv1}, (k == 12) ? 32'd1 : 32'd0);
         if (k % 3 == 0) begin
            check("t2_idx", {30'd0, bx1}, k / 3 - 1);
            check("t2_bit", {31'd0, bo1}, {31'd0, w[k/3-1]});
         end
      end
      check("t2_wo", {28'd0, wo1}, 32'h6);

      // Test 3: MSB-first, 1100 -> idx 3,2,1,0 bits 1,1,0,0
      iv2 = 1'b1; id2 = 4'b1100;
      tick();
      iv2 = 1'b0;
      check("t3_sel_start", {30'd0, ms2}, 32'd3);
      tick(); check("t3_idx3", {30'd0, bx2}, 32'd3); check("t3_b3", {31'd0, bo2}, 32'd1);
      tick(); check("t3_idx2", {30'd0, bx2}, 32'd2); check("t3_b2", {31'd0, bo2}, 32'd1);
      tick(); check("t3_idx1", {30'd0, bx2}, 32'd1); check("t3_b1", {31'd0, bo2}, 32'd0);
      tick(); check("t3_idx0", {30'd0, bx2}, 32'd0); check("t3_b0", {31'd0, bo2}, 32'd0);
      check("t3_wv", {31'd0, wv2}, 32'd1);
      check("t3_wo", {28'd0, wo2}, 32'hC);
      check("t3_sel_end", {30'd0, ms2}, 32'd3);

      // Test 4: in_valid held high, 0001 then 1000 changed mid-scan
      iv0 = 1'b1; id0 = 4'b0001;
      tick();
      id0 = 4'b1000;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("t4_ready_scan", {31'd0, rdy0}, 32'd0);
         check("t4_mi_stable", {28'd0, mi0}, 32'h1);
      end
      tick();
      check("t4_wv1", {31'd0, wv0}, 32'd1);
      check("t4_wo1", {28'd0, wo0}, 32'h1);
      check("t4_ready_idle", {31'd0, rdy0}, 32'd1);
      tick();
      iv0 = 1'b0;
      check("t4_accept2_busy", {31'd0, bz0}, 32'd1);
      check("t4_accept2_mi", {28'd0, mi0}, 32'h8);
      tick(); tick(); tick(); tick();
      check("t4_wv2", {31'd0, wv0}, 32'd1);
      check("t4_wo2", {28'd0, wo0}, 32'h8);

      // Test 5: reset after the second sample of 1111
      iv0 = 1'b1; id0 = 4'b1111;
      tick();
      iv0 = 1'b0;
      tick();
      tick();
      check("t5_pre_idx", {30'd0, bx0}, 32'd1);
      reset = 1'b1;
      tick();
      check("t5_busy", {31'd0, bz0}, 32'd0);
      check("t5_ready", {31'd0, rdy0}, 32'd0);
      check("t5_mi", {28'd0, mi0}, 32'd0);
      check("t5_sel", {30'd0, ms0}, 32'd0);
      check("t5_bv", {31'd0, bv0}, 32'd0);
      check("t5_bo", {31'd0, bo0}, 32'd0);
      check("t5_idx", {30'd0, bx0}, 32'd0);
      check("t5_wv", {31'd0, wv0}, 32'd0);
      check("t5_wo", {28'd0, wo0}, 32'd0);
      reset = 1'b0;
      #1;
      check("t5_ready_rel", {31'd0, rdy0}, 32'd1);
      w = 4'b0101;
      iv0 = 1'b1; id0 = w;
      tick();
      iv0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t5_bit", {31'd0, bo0}, {31'd0, w[k]});
         check("t5_wv_scan", {31'd0, wv0}, (k == 3) ? 32'd1 : 32'd0);
      end
      check("t5_wo", {28'd0, wo0}, 32'h5);

      // Test 6: back-to-back random words
      for (int n = 0; n < 100; n++) begin
         w = 4'($urandom_range(0, 15));
         iv0 = 1'b1; id0 = w;
         tick();
         check("t6_mi", {28'd0, mi0}, {28'd0, w});
         for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_bv", {31'd0, bv0}, 32'd1);
            check("t6_idx", {30'd0, bx0}, k);
            check("t6_bit", {31'd0, bo0}, {31'd0, w[bx0]});
         end
         check("t6_wv", {31'd0, wv0}, 32'd1);
         check("t6_wo", {28'd0, wo0}, {28'd0, w});
      end
      iv0 = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
